fetch_sequencer: RTL and testbench

//  Computes and sequences the next fetch PC for the IF stage register and I-cache, replacing ad-hoc

---
 rtl/fetch_sequencer_pkg.sv | 16 +
 rtl/fetch_sequencer_if.sv | 32 +++
 rtl/fetch_sequencer_next_pc_sel.sv | 42 ++++
 rtl/fetch_sequencer.sv | 141 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the IF-stage fetch sequencer.
// Holds the PC width, the reset PC, the FSM and PC-source enums, and the target alignment helper.
package fetch_sequencer_pkg;

    localparam int          DW       = 32;
    localparam logic [31:0] RESET_PC = 32'h0FFF_FFFC;

    typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, STALL = 2'd2} fetch_st_e;
    typedef enum logic [1:0] {SRC_SEQ = 2'd0, SRC_PRED = 2'd1, SRC_JMP = 2'd2, SRC_EXE = 2'd3} pc_src_e;

    // Instructions are word aligned, so the low two target bits are dropped.
    function automatic logic [DW-1:0] align_pc(input logic [DW-1:0] addr);
        return addr & {{(DW-2){1'b1}}, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch-side bundle: redirect sources, stalls, I-cache handshake and the pipeline flushes.
// The master modport is the sequencer; the slave modport is the surrounding pipeline and I-cache.
interface fetch_sequencer_if;
    import fetch_sequencer_pkg::*;

    logic          pred_taken;
    logic [DW-1:0] pred_target;
    logic          jump_id;
    logic [DW-1:0] jump_target;
    logic          redir_exe;
    logic [DW-1:0] redir_target;
    logic          istall;
    logic          dstall;
    logic          ic_ack;
    logic [DW-1:0] pc;
    logic          ic_req;
    logic          flush_if_id;
    logic          flush_id_exe;

    modport master (
        input  pred_taken, pred_target, jump_id, jump_target, redir_exe, redir_target,
        input  istall, dstall, ic_ack,
        output pc, ic_req, flush_if_id, flush_id_exe
    );

    modport slave (
        output pred_taken, pred_target, jump_id, jump_target, redir_exe, redir_target,
        output istall, dstall, ic_ack,
        input  pc, ic_req, flush_if_id, flush_id_exe
    );

endinterface

// File: rtl/fetch_sequencer_next_pc_sel.sv
// Next-PC priority mux: EXE redirect > pending redirect > ID jump > prediction > pc+4.
// Also reports which source won so the top can derive its flushes from it.
module fetch_sequencer_next_pc_sel
    import fetch_sequencer_pkg::*;
(
    input  logic [DW-1:0] pc,
    input  logic          redir_exe,
    input  logic [DW-1:0] redir_target,
    input  logic          pend_vld,
    input  logic          pend_exe,
    input  logic [DW-1:0] pend_tgt,
    input  logic          jump_id,
    input  logic [DW-1:0] jump_target,
    input  logic          pred_taken,
    input  logic [DW-1:0] pred_target,
    output logic [DW-1:0] next_pc,
    output pc_src_e       src
);

    // Priority select; a replayed pending redirect keeps the class of its original source.
    always_comb begin
        next_pc = pc + DW'(4);
        src     = SRC_SEQ;
        if (redir_exe) begin
            next_pc = align_pc(redir_target);
            src     = SRC_EXE;
        end else if (pend_vld) begin
            next_pc = align_pc(pend_tgt);
            src     = pend_exe ? SRC_EXE : SRC_JMP;
        end else if (jump_id) begin
            next_pc = align_pc(jump_target);
            src     = SRC_JMP;
        end else if (pred_taken) begin
            next_pc = align_pc(pred_target);
            src     = SRC_PRED;
        end else begin
            next_pc = pc + DW'(4);
            src     = SRC_SEQ;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch PC sequencer: BOOT/RUN/STALL FSM, redirect holding across stalls, I-cache request
// and IF/ID, ID/EXE flush generation.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    fetch_sequencer_if.master bus
);

    fetch_st_e     state_q, state_d;
    logic [DW-1:0] pc_q, pc_d;
    logic          ic_req_q, ic_req_d;
    logic          pend_vld_q, pend_vld_d;
    logic          pend_exe_q, pend_exe_d;
    logic [DW-1:0] pend_tgt_q, pend_tgt_d;

    logic          stall_s;
    logic          redirect_s;
    logic          active_s;
    logic [DW-1:0] next_pc_s;
    pc_src_e       src_s;

    assign stall_s = bus.istall | bus.dstall;

    fetch_sequencer_next_pc_sel u_sel (
        .pc           (pc_q),
        .redir_exe    (bus.redir_exe),
        .redir_target (bus.redir_target),
        .pend_vld     (pend_vld_q),
        .pend_exe     (pend_exe_q),
        .pend_tgt     (pend_tgt_q),
        .jump_id      (bus.jump_id),
        .jump_target  (bus.jump_target),
        .pred_taken   (bus.pred_taken),
        .pred_target  (bus.pred_target),
        .next_pc      (next_pc_s),
        .src          (src_s)
    );

    assign redirect_s = (src_s == SRC_EXE) || (src_s == SRC_JMP);
    assign active_s   = !rst && (state_q != BOOT) && !stall_s;

    // Flushes track the winning redirect of this cycle and are held off while stalled.
    always_comb begin
        bus.flush_if_id  = 1'b0;
        bus.flush_id_exe = 1'b0;
        if (active_s) begin
            bus.flush_if_id  = redirect_s;
            bus.flush_id_exe = (src_s == SRC_EXE);
        end else begin
            bus.flush_if_id  = 1'b0;
            bus.flush_id_exe = 1'b0;
        end
    end

    // Next-state, PC and pending-redirect logic.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ic_req_d   = ic_req_q;
        pend_vld_d = pend_vld_q;
        pend_exe_d = pend_exe_q;
        pend_tgt_d = pend_tgt_q;

        // A redirect seen while stalled is parked; an ID jump never displaces an EXE redirect.
        if (stall_s && (state_q != BOOT)) begin
            if (bus.redir_exe && !(pend_vld_q && pend_exe_q)) begin
                pend_vld_d = 1'b1;
                pend_exe_d = 1'b1;
                pend_tgt_d = bus.redir_target;
            end else if (bus.jump_id && !bus.redir_exe && !pend_vld_q) begin
                pend_vld_d = 1'b1;
                pend_exe_d = 1'b0;
                pend_tgt_d = bus.jump_target;
            end else begin
                pend_vld_d = pend_vld_q;
            end
        end else begin
            pend_vld_d = pend_vld_q;
        end

        case (state_q)
            BOOT: begin
                pc_d     = RESET_PC + 32'd4;
                ic_req_d = 1'b1;
                state_d  = RUN;
            end
            RUN: begin
                if (stall_s) begin
                    ic_req_d = 1'b0;
                    state_d  = STALL;
                end else if (redirect_s || bus.ic_ack) begin
                    pc_d     = next_pc_s;
                    ic_req_d = 1'b1;
                end else begin
                    ic_req_d = 1'b1;
                end
            end
            STALL: begin
                if (stall_s) begin
                    ic_req_d = 1'b0;
                end else begin
                    state_d    = RUN;
                    ic_req_d   = 1'b1;
                    pend_vld_d = 1'b0;
                    pend_exe_d = 1'b0;
                    pc_d       = redirect_s ? next_pc_s : pc_q;
                end
            end
            default: begin
                state_d  = BOOT;
                pc_d     = RESET_PC;
                ic_req_d = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            ic_req_q   <= 1'b0;
            pend_vld_q <= 1'b0;
            pend_exe_q <= 1'b0;
            pend_tgt_q <= {DW{1'b0}};
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ic_req_q   <= ic_req_d;
            pend_vld_q <= pend_vld_d;
            pend_exe_q <= pend_exe_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

    assign bus.pc     = pc_q;
    assign bus.ic_req = ic_req_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench: directed scenarios then random traffic, all compared against a
// behavioural model of the fetch rules (phase, pending redirect rank, winning source).
module tb_fetch_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_sequencer_if bus ();

    fetch_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model: phase 0 = booting, 1 = fetching, 2 = held by a stall.
    logic [31:0] m_pc    = 32'h0FFF_FFFC;
    logic        m_req   = 1'b0;
    int          m_phase = 0;
    int          m_prank = 0;   // 0 none, 1 ID jump, 2 EXE redirect
    logic [31:0] m_ptgt  = 32'd0;

    logic obs_fif;
    logic obs_fie;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic pt, input logic [31:0] ptg,
                        input logic jid, input logic [31:0] jtg,
                        input logic rex, input logic [31:0] rtg,
                        input logic is, input logic ds, input logic ack);
        logic        stl;
        int          w_rank;
        logic [31:0] w_tgt;
        logic        live;
        int          n_rank;
        logic [31:0] n_tgt;
        @(negedge clk);
        rst              = r;
        bus.pred_taken   = pt;
        bus.pred_target  = ptg;
        bus.jump_id      = jid;
        bus.jump_target  = jtg;
        bus.redir_exe    = rex;
        bus.redir_target = rtg;
        bus.istall       = is;
        bus.dstall       = ds;
        bus.ic_ack       = ack;
        #1;
        stl = is | ds;
        if (rex)              begin w_rank = 2;       w_tgt = rtg;    end
        else if (m_prank > 0) begin w_rank = m_prank; w_tgt = m_ptgt; end
        else if (jid)         begin w_rank = 1;       w_tgt = jtg;    end
        else                  begin w_rank = 0;       w_tgt = 32'd0;  end
        w_tgt = w_tgt & 32'hFFFF_FFFC;
        live  = !r && (m_phase != 0) && !stl;

        check_val("pc", bus.pc, m_pc);
        check_val("ic_req", 32'(bus.ic_req), 32'(m_req));
        check_val("flush_if_id", 32'(bus.flush_if_id), 32'(live && w_rank > 0));
        check_val("flush_id_exe", 32'(bus.flush_id_exe), 32'(live && w_rank == 2));
        obs_fif = bus.flush_if_id;
        obs_fie = bus.flush_id_exe;

        n_rank = rex ? 2 : (jid ? 1 : 0);
        n_tgt  = rex ? rtg : jtg;
        if (r) begin
            m_pc = 32'h0FFF_FFFC; m_req = 1'b0; m_phase = 0; m_prank = 0;
        end else if (m_phase == 0) begin
            m_pc = 32'h1000_0000; m_req = 1'b1; m_phase = 1;
        end else if (stl) begin
            if (n_rank > m_prank) begin m_prank = n_rank; m_ptgt = n_tgt; end
            m_req = 1'b0; m_phase = 2;
        end else if (m_phase == 2) begin
            if (w_rank > 0) m_pc = w_tgt;
            m_req = 1'b1; m_phase = 1; m_prank = 0;
        end else begin
            if (w_rank > 0)  m_pc = w_tgt;
            else if (ack)    m_pc = pt ? (ptg & 32'hFFFF_FFFC) : m_pc + 32'd4;
            m_req = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ack);
        step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, ack);
    endtask

    initial begin
        bus.pred_taken = 1'b0; bus.pred_target = 32'd0;
        bus.jump_id = 1'b0;    bus.jump_target = 32'd0;
        bus.redir_exe = 1'b0;  bus.redir_target = 32'd0;
        bus.istall = 1'b0;     bus.dstall = 1'b0; bus.ic_ack = 1'b0;

        // Reset, boot, sequential fetch.
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        check_val("t1_rst_pc", bus.pc, 32'h0FFF_FFFC);
        idle(1'b0);
        check_val("t1_boot_pc", bus.pc, 32'h1000_0000);
        check_val("t1_boot_req", 32'(bus.ic_req), 32'd1);
        idle(1'b1);
        idle(1'b1);
        check_val("t1_seq_pc", bus.pc, 32'h1000_0008);

        // Predicted taken.
        step(1'b0, 1'b1, 32'h1000_0100, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        check_val("t2_pc", bus.pc, 32'h1000_0100);
        check_val("t2_fif", 32'(obs_fif), 32'd0);

        // EXE redirect and ID jump together.
        step(1'b0, 1'b0, 32'd0, 1'b1, 32'h1000_0200, 1'b1, 32'h1000_0040, 1'b0, 1'b0, 1'b0);
        check_val("t3_pc", bus.pc, 32'h1000_0040);
        check_val("t3_fif", 32'(obs_fif), 32'd1);
        check_val("t3_fie", 32'(obs_fie), 32'd1);

        // Redirect during a 5-cycle I-cache miss.
        step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h1000_0080, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        check_val("t4_hold_pc", bus.pc, 32'h1000_0040);
        check_val("t4_req_low", 32'(bus.ic_req), 32'd0);
        idle(1'b0);
        check_val("t4_fif", 32'(obs_fif), 32'd1);
        check_val("t4_fie", 32'(obs_fie), 32'd1);
        check_val("t4_pc", bus.pc, 32'h1000_0080);
        idle(1'b0);
        check_val("t4_once", 32'(obs_fif), 32'd0);

        // Wrap at the top of the address space.
        step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        idle(1'b1);
        check_val("t5_wrap", bus.pc, 32'h0000_0000);

        // Reset while stalled with a pending redirect.
        step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b1, 32'h1000_0300, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        check_val("t6_pc", bus.pc, 32'h0FFF_FFFC);
        check_val("t6_req", 32'(bus.ic_req), 32'd0);
        idle(1'b0);
        idle(1'b0);
        check_val("t6_boot_pc", bus.pc, 32'h1000_0000);
        check_val("t6_no_flush", 32'(obs_fif), 32'd0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 299) == 0,
                 $urandom_range(0, 3) == 0, $urandom,
                 $urandom_range(0, 7) == 0, $urandom,
                 $urandom_range(0, 7) == 0, $urandom,
                 $urandom_range(0, 4) == 0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 1) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
